// File: rtl/icache_pkg.sv
// icache shared definitions: FSM state encoding
// and the word-address helper.
package icache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  function automatic logic [31:0] word_addr(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_array.sv
// icache line storage: LINES x {valid, tag, data}.
// Ports: clk/rst, async read (rd_*), sync write (wr_*), flush_i clears all valid bits.
module icache_array
  import icache_pkg::*;
#(
  parameter int LINES = 64,
  localparam int IDX = $clog2(LINES),
  localparam int TW = 30 - IDX
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush_i,
  input  logic [IDX-1:0] rd_idx_i,
  output logic           rd_valid_o,
  output logic [TW-1:0]  rd_tag_o,
  output logic [31:0]    rd_data_o,
  input  logic           we_i,
  input  logic [IDX-1:0] wr_idx_i,
  input  logic [TW-1:0]  wr_tag_i,
  input  logic [31:0]    wr_data_i
);

  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  // A flush in the same cycle as a fill leaves the line invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, one word per line.
// Ports: mem_* core side, bus_* backing memory, flush, hit/miss counters.
module icache
  import icache_pkg::*;
#(
  parameter int LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        bus_valid,
  output logic [31:0] bus_addr,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        flush,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IDX = $clog2(LINES);
  localparam int TW  = 30 - IDX;

  state_e      state_q, state_d;
  logic        mem_ready_q, mem_ready_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        bus_valid_q, bus_valid_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] hit_q, hit_d;
  logic [31:0] miss_q, miss_d;

  logic          line_valid;
  logic [TW-1:0] line_tag;
  logic [31:0]   line_data;
  logic          we;
  logic          accept;
  logic          hit;

  logic unused_ok;
  assign unused_ok = ^{mem_addr[1:0], bus_addr_q[1:0]};

  // The fill target index/tag live in bus_addr_q.
  icache_array #(.LINES(LINES)) u_array (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush),
    .rd_idx_i  (mem_addr[IDX+1:2]),
    .rd_valid_o(line_valid),
    .rd_tag_o  (line_tag),
    .rd_data_o (line_data),
    .we_i      (we),
    .wr_idx_i  (bus_addr_q[IDX+1:2]),
    .wr_tag_i  (bus_addr_q[31:IDX+2]),
    .wr_data_i (bus_rdata)
  );

  assign accept = mem_valid && !mem_ready_q;
  assign hit    = line_valid && (line_tag == mem_addr[31:IDX+2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      bus_valid_q <= 1'b0;
      bus_addr_q  <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      bus_valid_q <= bus_valid_d;
      bus_addr_q  <= bus_addr_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_ready_d = 1'b0;
    mem_rdata_d = mem_rdata_q;
    bus_valid_d = bus_valid_q;
    bus_addr_d  = bus_addr_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    we          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (hit) begin
            mem_rdata_d = line_data;
            mem_ready_d = 1'b1;
            hit_d       = hit_q + 32'd1;
          end else begin
            bus_valid_d = 1'b1;
            bus_addr_d  = word_addr(mem_addr);
            miss_d      = miss_q + 32'd1;
            state_d     = FILL;
          end
        end
      end
      FILL: begin
        if (bus_ready) begin
          bus_valid_d = 1'b0;
          we          = 1'b1;
          mem_rdata_d = bus_rdata;
          mem_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_ready  = mem_ready_q;
  assign mem_rdata  = mem_rdata_q;
  assign bus_valid  = bus_valid_q;
  assign bus_addr   = bus_addr_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: table of reads plus
// hand sequences for flush-on-fill and reset mid-fill.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        bus_valid;
  logic [31:0] bus_addr;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        flush;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_pass = 0;
  int n_total = 0;
  int fills = 0;
  logic [31:0] last_bus_addr = '0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  icache #(.LINES(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .bus_valid (bus_valid),
    .bus_addr  (bus_addr),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata),
    .flush     (flush),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a[31:2])
      30'd0:   return 32'hff000000;
      30'd1:   return 32'hfe000000;
      30'd64:  return 32'h12345678;
      default: return 32'h0;
    endcase
  endfunction

  // 1-cycle backing memory
  always @(posedge clk) begin
    if (bus_valid && !bus_ready) begin
      bus_ready <= 1'b1;
      bus_rdata <= mem_word(bus_addr);
    end else begin
      bus_ready <= 1'b0;
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // scoreboard pop + fill monitor
  always @(negedge clk) begin
    if (mem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_mem_ready", 32'd1, 32'd0);
      end else begin
        chk("rdata", mem_rdata, exp_q.pop_front());
      end
    end
    if (bus_valid === 1'b1 && bus_ready === 1'b1) begin
      fills++;
      last_bus_addr = bus_addr;
    end
  end

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr,
                         input logic [31:0] exp,
                         input int lat,
                         input bit flush_on_fill);
    int cnt;
    bit done;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = addr;
    exp_q.push_back(exp);
    cnt  = 0;
    done = 0;
    while (!done && cnt < 20) begin
      @(negedge clk);
      cnt++;
      flush = flush_on_fill && bus_ready;
      if (mem_ready) done = 1;
    end
    mem_valid = 1'b0;
    flush     = 1'b0;
    chk("latency", cnt, lat);
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          flush_before;
    logic [31:0] data;
    int          lat;
    int          hits;
    int          misses;
    int          fills;
    logic [31:0] last;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'h000, 0, 32'hff000000, 3, 0, 1, 1, 32'h000};
    vecs[1] = '{32'h000, 0, 32'hff000000, 1, 1, 1, 1, 32'h000};
    vecs[2] = '{32'h003, 0, 32'hff000000, 1, 2, 1, 1, 32'h000};
    vecs[3] = '{32'h100, 0, 32'h12345678, 3, 2, 2, 2, 32'h100};
    vecs[4] = '{32'h000, 0, 32'hff000000, 3, 2, 3, 3, 32'h000};
    vecs[5] = '{32'h004, 0, 32'hfe000000, 3, 2, 4, 4, 32'h004};
    vecs[6] = '{32'h004, 1, 32'hfe000000, 3, 2, 5, 5, 32'h004};

    rst       = 1'b1;
    mem_valid = 1'b0;
    mem_addr  = '0;
    flush     = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
    fills = 0;

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].flush_before) pulse_flush();
      do_read(vecs[i].addr, vecs[i].data, vecs[i].lat, 0);
      chk($sformatf("v%0d_hits", i), hit_count, vecs[i].hits);
      chk($sformatf("v%0d_misses", i), miss_count, vecs[i].misses);
      chk($sformatf("v%0d_fills", i), fills, vecs[i].fills);
      chk($sformatf("v%0d_bus_addr", i), last_bus_addr, vecs[i].last);
    end

    // flush coincident with fill completion
    pulse_flush();
    do_read(32'h4, 32'hfe000000, 3, 1);
    chk("ff_misses", miss_count, 32'd6);
    do_read(32'h4, 32'hfe000000, 3, 0);
    chk("ff_misses2", miss_count, 32'd7);
    chk("ff_hits", hit_count, 32'd2);
    chk("ff_fills", fills, 32'd7);

    // reset mid-fill
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = 32'h0;
    @(negedge clk);
    chk("mid_bus_valid", {31'd0, bus_valid}, 32'd1);
    rst       = 1'b1;
    mem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_bus_valid", {31'd0, bus_valid}, 32'd0);
    chk("mid_rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("mid_rst_hits", hit_count, 32'd0);
    chk("mid_rst_misses", miss_count, 32'd0);
    @(negedge clk);
    chk("late_ready_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("late_ready_bus_valid", {31'd0, bus_valid}, 32'd0);
    fills = 0;
    do_read(32'h0, 32'hff000000, 3, 0);
    chk("post_rst_misses", miss_count, 32'd1);
    chk("post_rst_hits", hit_count, 32'd0);
    chk("post_rst_fills", fills, 32'd1);
    chk("post_rst_bus_addr", last_bus_addr, 32'd0);
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
